// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings for the EXE-stage multiply/divide sequencer: req_op values
// (also used by the ALU decode) and the controller state encoding.
package muldiv_ctrl_pkg;

  localparam logic [1:0] MD_MULT  = 2'd0;
  localparam logic [1:0] MD_MULTU = 2'd1;
  localparam logic [1:0] MD_DIV   = 2'd2;
  localparam logic [1:0] MD_DIVU  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_MUL       = 3'd1,
    ST_DIV_ISSUE = 3'd2,
    ST_DIV_WAIT  = 3'd3,
    ST_DONE      = 3'd4,
    ST_DRAIN     = 3'd5
  } state_t;

endpackage

// File: rtl/muldiv_ctrl.sv
// Sequences one MULT/MULTU/DIV/DIVU at a time over an external pipelined
// multiplier and AXI-stream divider, returning a registered {HI,LO} result.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        cancel,
  input  logic        ack,
  output logic        done,
  output logic        busy,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        mul_start,
  output logic        mul_signed,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_product,
  output logic        div_s_tvalid,
  input  logic        div_s_tready,
  output logic        div_signed,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic        div_dout_tvalid,
  input  logic [63:0] div_dout,
  output logic [2:0]  fsm_state
);

  localparam int CW = $clog2(MUL_LAT + 1);

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [31:0]   src1_q, src2_q, hi_q, lo_q;
  logic          sign_q;
  logic          accept, cap_mul, cap_div, mul_hit;

  assign mul_hit = (cnt == CW'(MUL_LAT));

  // Handshakes: the divider input transfers on any cycle where div_s_tvalid and
  // div_s_tready are both high; div_s_tvalid never drops before that transfer
  // unless cancel aborts it. div_dout_tvalid is a one-cycle result strobe (no
  // back-pressure). done/ack follow the same rule as valid/ready.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    cap_mul  = 1'b0;
    cap_div  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid && !cancel) begin
          accept   = 1'b1;
          state_nx = req_op[1] ? ST_DIV_ISSUE : ST_MUL;
        end
      end
      ST_MUL: begin
        if (cancel) state_nx = ST_IDLE;
        else if (mul_hit) begin
          cap_mul  = 1'b1;
          state_nx = ST_DONE;
        end
      end
      ST_DIV_ISSUE: begin
        // A cancelled request already handed to the core must still be drained.
        if (cancel) state_nx = div_s_tready ? ST_DRAIN : ST_IDLE;
        else if (div_s_tready) state_nx = ST_DIV_WAIT;
      end
      ST_DIV_WAIT: begin
        if (cancel) state_nx = div_dout_tvalid ? ST_IDLE : ST_DRAIN;
        else if (div_dout_tvalid) begin
          cap_div  = 1'b1;
          state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        if (cancel || ack) state_nx = ST_IDLE;
      end
      ST_DRAIN: begin
        if (div_dout_tvalid) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      src1_q <= '0;
      src2_q <= '0;
      sign_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= (state == ST_MUL && state_nx == ST_MUL) ? cnt + CW'(1) : '0;
      if (accept) begin
        src1_q <= src1;
        src2_q <= src2;
        sign_q <= ~req_op[0];
      end
      if (cap_mul) begin
        hi_q <= mul_product[63:32];
        lo_q <= mul_product[31:0];
      end else if (cap_div) begin
        // Divider packs {quotient, remainder}; LO takes the quotient.
        lo_q <= div_dout[63:32];
        hi_q <= div_dout[31:0];
      end
    end
  end

  assign done         = (state == ST_DONE);
  assign busy         = (state != ST_IDLE);
  assign mul_start    = (state == ST_MUL) && (cnt == '0);
  assign div_s_tvalid = (state == ST_DIV_ISSUE);
  assign hi_out       = hi_q;
  assign lo_out       = lo_q;
  assign mul_signed   = sign_q;
  assign mul_a        = src1_q;
  assign mul_b        = src2_q;
  assign div_signed   = sign_q;
  assign div_dividend = src1_q;
  assign div_divisor  = src2_q;
  assign fsm_state    = state;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: behavioural multiplier pipeline and
// a task-driven divider core, with a queue of expected {HI,LO} results.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  localparam int MUL_LAT = 2;

  logic        clk, reset, req_valid, cancel, ack;
  logic [1:0]  req_op;
  logic [31:0] src1, src2;
  logic        done, busy, mul_start, mul_signed, div_s_tvalid, div_s_tready, div_signed;
  logic [31:0] hi_out, lo_out, mul_a, mul_b, div_dividend, div_divisor;
  logic [63:0] mul_product, div_dout;
  logic        div_dout_tvalid;
  logic [2:0]  fsm_state;

  muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .src1(src1), .src2(src2), .cancel(cancel), .ack(ack),
    .done(done), .busy(busy), .hi_out(hi_out), .lo_out(lo_out),
    .mul_start(mul_start), .mul_signed(mul_signed), .mul_a(mul_a), .mul_b(mul_b),
    .mul_product(mul_product), .div_s_tvalid(div_s_tvalid), .div_s_tready(div_s_tready),
    .div_signed(div_signed), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_dout_tvalid(div_dout_tvalid), .div_dout(div_dout), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference models ----------------
  function automatic logic [63:0] mul_model(input logic [31:0] a, b, input logic sgn);
    logic signed [63:0] sa, sb;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    if (sgn) return sa * sb;
    return {32'b0, a} * {32'b0, b};
  endfunction

  function automatic logic [63:0] div_model(input logic [31:0] a, b, input logic sgn);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = '1;
      r = a;
    end else if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  // Multiplier: product valid exactly MUL_LAT cycles after mul_start, junk otherwise.
  logic [63:0] mp [MUL_LAT];
  logic        mv [MUL_LAT];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MUL_LAT; i++) begin
        mv[i] <= 1'b0;
        mp[i] <= '0;
      end
    end else begin
      mv[0] <= mul_start;
      mp[0] <= mul_model(mul_a, mul_b, mul_signed);
      for (int i = 1; i < MUL_LAT; i++) begin
        mv[i] <= mv[i-1];
        mp[i] <= mp[i-1];
      end
    end
  end
  assign mul_product = mv[MUL_LAT-1] ? mp[MUL_LAT-1] : 64'hDEAD_BEEF_0BAD_F00D;

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  logic [63:0] last_res;
  logic [31:0] core_a, core_b;
  logic        core_sgn;
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [1:0] op, input logic [31:0] a, b);
    req_valid = 1'b1;
    req_op    = op;
    src1      = a;
    src2      = b;
    step();
    req_valid = 1'b0;
    src1      = $urandom;
    src2      = $urandom;
  endtask

  task automatic div_issue(input int rdy_dly, input logic [31:0] a, b);
    for (int i = 0; i < rdy_dly; i++) begin
      check("div_tvalid_wait", div_s_tvalid, 1'b1);
      check("div_operands_stable", {div_dividend, div_divisor}, {a, b});
      step();
    end
    check("div_tvalid", div_s_tvalid, 1'b1);
    div_s_tready = 1'b1;
    core_a   = div_dividend;
    core_b   = div_divisor;
    core_sgn = div_signed;
    step();
    div_s_tready = 1'b0;
  endtask

  task automatic div_return(input int out_dly);
    repeat (out_dly) step();
    div_dout_tvalid = 1'b1;
    div_dout        = div_model(core_a, core_b, core_sgn);
    step();
    div_dout_tvalid = 1'b0;
    div_dout        = {$urandom, $urandom};
  endtask

  task automatic collect(input string tag);
    int n;
    logic [63:0] e;
    n = 0;
    while (!done && n < 50) begin
      step();
      n++;
    end
    check({tag, "_done_seen"}, done, 1'b1);
    if (exp_q.size() == 0) begin
      check({tag, "_queue_nonempty"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      check(tag, {hi_out, lo_out}, e);
      last_res = e;
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    check({tag, "_idle_after_ack"}, busy, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_flags"}, {done, busy, mul_start, div_s_tvalid, mul_signed, div_signed}, 6'b0);
    check({tag, "_result"}, {hi_out, lo_out}, 64'd0);
    check({tag, "_operands"}, {mul_a, mul_b, div_dividend, div_divisor}, 128'd0);
    check({tag, "_state"}, fsm_state, ST_IDLE);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [63:0] m;
    reset = 1'b1; req_valid = 1'b0; req_op = '0; src1 = '0; src2 = '0;
    cancel = 1'b0; ack = 1'b0; div_s_tready = 1'b0; div_dout_tvalid = 1'b0; div_dout = '0;
    last_res = '0;
    step();
    step();
    check_all_zero("reset");
    reset = 1'b0;
    step();

    // cancel together with req_valid in IDLE: no acceptance
    req_valid = 1'b1; req_op = MD_MULT; cancel = 1'b1;
    step();
    req_valid = 1'b0; cancel = 1'b0;
    check("idle_cancel_blocks_accept", busy, 1'b0);

    // MULT -3*5: cycle-exact latency, then DONE held with ack low
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFF1);
    send_req(MD_MULT, 32'hFFFF_FFFD, 32'd5);
    check("mult_start_c1", {mul_start, mul_signed}, 2'b11);
    check("mult_operands", {mul_a, mul_b}, {32'hFFFF_FFFD, 32'd5});
    step();
    check("mult_c2", {mul_start, done}, 2'b00);
    step();
    check("mult_c3_done", done, 1'b0);
    step();
    check("mult_c4_done", done, 1'b1);
    check("mult_result", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFF1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("done_hold", {done, hi_out, lo_out}, {1'b1, 64'hFFFF_FFFF_FFFF_FFF1});
    end
    req_valid = 1'b1; req_op = MD_MULT;
    collect("mult_ack");
    req_valid = 1'b0;
    check("no_accept_with_ack", fsm_state, ST_IDLE);

    // DIVU 100/7 with tready delayed 3 cycles
    exp_q.push_back({32'd2, 32'd14});
    send_req(MD_DIVU, 32'd100, 32'd7);
    check("divu_signed", div_signed, 1'b0);
    div_issue(3, 32'd100, 32'd7);
    check("divu_wait_state", fsm_state, ST_DIV_WAIT);
    div_return(2);
    check("divu_done_next", done, 1'b1);
    collect("divu_100_7");

    // DIV -7/2
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
    send_req(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    check("div_signed", div_signed, 1'b1);
    div_issue(0, 32'hFFFF_FFF9, 32'd2);
    div_return(1);
    collect("div_m7_2");

    // cancel in DIV_WAIT -> DRAIN, queued MULTU accepted only afterwards
    send_req(MD_DIVU, 32'd50, 32'd3);
    div_issue(1, 32'd50, 32'd3);
    step();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    check("drain_entered", fsm_state, ST_DRAIN);
    exp_q.push_back({32'd1, 32'hFFFF_FFFE});
    req_valid = 1'b1; req_op = MD_MULTU; src1 = 32'hFFFF_FFFF; src2 = 32'd2;
    for (int i = 0; i < 3; i++) begin
      check("drain_flags", {busy, done, mul_start}, 3'b100);
      check("drain_state", fsm_state, ST_DRAIN);
      step();
    end
    div_dout_tvalid = 1'b1; div_dout = 64'h1234_5678_9ABC_DEF0;
    step();
    div_dout_tvalid = 1'b0;
    check("drain_exit", fsm_state, ST_IDLE);
    check("drain_discard", {hi_out, lo_out}, last_res);
    step();
    req_valid = 1'b0;
    check("multu_after_drain", fsm_state, ST_MUL);
    collect("multu_ffff_2");

    // cancel in MUL: back to IDLE, later product ignored
    send_req(MD_MULT, 32'd9, 32'd9);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    check("mul_cancel_idle", busy, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("mul_cancel_quiet", {done, busy, hi_out, lo_out}, {2'b00, last_res});
    end

    // cancel in DIV_ISSUE without and with a handshake
    send_req(MD_DIV, 32'd8, 32'd2);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    check("issue_cancel_idle", fsm_state, ST_IDLE);
    send_req(MD_DIV, 32'd8, 32'd2);
    cancel = 1'b1; div_s_tready = 1'b1;
    step();
    cancel = 1'b0; div_s_tready = 1'b0;
    check("issue_cancel_drain", fsm_state, ST_DRAIN);
    div_dout_tvalid = 1'b1;
    step();
    div_dout_tvalid = 1'b0;
    check("issue_drain_exit", {fsm_state, done, hi_out, lo_out}, {ST_IDLE, 1'b0, last_res});

    // cancel in DIV_WAIT with result the same cycle: straight to IDLE
    send_req(MD_DIVU, 32'd77, 32'd5);
    div_issue(0, 32'd77, 32'd5);
    cancel = 1'b1; div_dout_tvalid = 1'b1; div_dout = div_model(core_a, core_b, core_sgn);
    step();
    cancel = 1'b0; div_dout_tvalid = 1'b0;
    check("wait_cancel_same_cycle", {fsm_state, hi_out, lo_out}, {ST_IDLE, last_res});

    // cancel in DONE discards the result
    send_req(MD_MULTU, 32'd6, 32'd7);
    repeat (MUL_LAT + 1) step();
    check("done_before_cancel", done, 1'b1);
    last_res = {hi_out, lo_out};
    check("done_cancel_value", last_res, 64'd42);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    check("done_cancel_idle", {done, busy}, 2'b00);

    // divide by zero passes the core output through
    exp_q.push_back({32'd123, 32'hFFFF_FFFF});
    send_req(MD_DIVU, 32'd123, 32'd0);
    div_issue(0, 32'd123, 32'd0);
    div_return(0);
    collect("div_by_zero");

    // random operations with random handshake delays
    for (int t = 0; t < 10; t++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = (t % 3 == 0) ? 32'($urandom_range(1, 50)) : $urandom;
      if (op == MD_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
      if (op[1]) begin
        m = div_model(a, b, ~op[0]);
        exp_q.push_back({m[31:0], m[63:32]});
        send_req(op, a, b);
        div_issue($urandom_range(0, 3), a, b);
        div_return($urandom_range(0, 3));
      end else begin
        exp_q.push_back(mul_model(a, b, ~op[0]));
        send_req(op, a, b);
      end
      collect("random_op");
    end

    // reset in MUL and in DIV_ISSUE
    send_req(MD_MULT, 32'd3, 32'd4);
    step();
    reset = 1'b1;
    step();
    check_all_zero("reset_in_mul");
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("no_stray_done_mul", {done, busy}, 2'b00);
    end
    send_req(MD_DIV, 32'd30, 32'd5);
    check("in_div_issue", fsm_state, ST_DIV_ISSUE);
    reset = 1'b1;
    step();
    check_all_zero("reset_in_div");
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("no_stray_done_div", {done, busy}, 2'b00);
    end

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
